mult_seq_ctrl: RTL and testbench

//  Operand sequencer for the 8x8 shift-add sequential multiplier. Accepts operand pairs over a

---
 rtl/mult_pkg.sv | 10 +
 rtl/mult_wait_timer.sv | 23 ++
 rtl/mult_seq_ctrl.sv | 92 +++++++++
 tb/tb_mult_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential multiplier controller
//   state_t      controller FSM states
//   MULT_LAT_DEF default multiplier latency in cycles
//   OPD_W/PRD_W  operand and product widths
package mult_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
    localparam int MULT_LAT_DEF = 10;
    localparam int OPD_W = 8;
    localparam int PRD_W = 16;
endpackage

// File: rtl/mult_wait_timer.sv
// mult_wait_timer: clear/enable up-counter flagging the last multiplier latency cycle
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   clear  in  zero the counter (wins over en)
//   en     in  count up by one
//   hit    out counter equals MULT_LAT-1
module mult_wait_timer #(
    parameter int CNT_W = 4,
    parameter int MULT_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign hit = cnt == CNT_W'(MULT_LAT - 1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: operand sequencer for the 8x8 shift-add sequential multiplier
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake, in_a/in_b unsigned operands
//   mult_load/mult_a/mult_b  load pulse and held operands towards the multiplier
//   mult_op                  product returned by the multiplier
//   out_valid/out_ready      product handshake, out_product = in_a*in_b
//   busy                     not idle
//   ops_done                 products accepted downstream, wrapping
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNT_W = 4,
    parameter int OPS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             mult_load,
    output logic [7:0]       mult_a,
    output logic [7:0]       mult_b,
    input  logic [15:0]      mult_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_product,
    output logic             busy,
    output logic [OPS_W-1:0] ops_done
);
    state_t state, nxt;
    logic [OPD_W-1:0] a_r, b_r;
    logic [PRD_W-1:0] p_r;
    logic [OPS_W-1:0] ops_r;
    logic hit;
    mult_wait_timer #(.CNT_W(CNT_W), .MULT_LAT(MULT_LAT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .en    (state == WAIT),
        .hit   (hit)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // A zero operand skips the multiplier entirely: the product is known to be 0.
    always_comb begin
        nxt = state;
        in_ready = 1'b0;
        mult_load = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = (in_a == '0 || in_b == '0) ? DONE : LOAD;
            end
            LOAD: begin
                mult_load = 1'b1;
                nxt = WAIT;
            end
            WAIT: nxt = hit ? DONE : WAIT;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
            ops_r <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_r <= in_a;
                b_r <= in_b;
                if (in_a == '0 || in_b == '0) p_r <= '0;
            end
            if (state == WAIT && hit) p_r <= mult_op;
            if (state == DONE && out_ready) ops_r <= ops_r + 1'b1;
        end
    end
    assign mult_a = a_r;
    assign mult_b = b_r;
    assign out_product = p_r;
    assign busy = state != IDLE;
    assign ops_done = ops_r;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: self-checking bench for mult_seq_ctrl with a behavioural multiplier behind it
module tb_mult_seq_ctrl;
    localparam int LAT = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic in_ready, mult_load, out_valid, busy;
    logic [7:0] mult_a, mult_b;
    logic [15:0] mult_op, out_product, ops_done;
    int n_chk = 0;
    int n_err = 0;
    int exp_ops = 0;

    mult_seq_ctrl #(.MULT_LAT(LAT), .CNT_W(4), .OPS_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mult_load   (mult_load),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_op     (mult_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product becomes valid LAT cycles after the load cycle,
    // and shows a scrambled value before that so early capture is visible.
    logic [15:0] m_prod = '0;
    int m_cnt = 0;
    always @(posedge clk) begin
        if (reset) m_cnt <= 0;
        else if (mult_load) begin
            m_prod <= 16'(mult_a) * 16'(mult_b);
            m_cnt <= 1;
        end else if (m_cnt < 1000) m_cnt <= m_cnt + 1;
    end
    assign mult_op = (m_cnt >= LAT) ? m_prod : (m_prod ^ 16'h5A5A ^ 16'(m_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One operation through the handshakes, with `hold` cycles of output backpressure.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          input logic [15:0] p, input int lat);
        int n;
        int loads;
        int bad;
        int bad2;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        if (!in_ready) return;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        loads = 0;
        bad = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a = ~a;
            in_b = ~b;
            n++;
            loads += int'(mult_load);
            if (in_ready) bad++;
            if (lat > 1 && (mult_a !== a || mult_b !== b)) bad++;
        end while (!out_valid && n < 40);
        chk("latency", 32'(n), 32'(lat));
        chk("mult_load_pulses", 32'(loads), 32'(lat > 1 ? 1 : 0));
        chk("busy_window", 32'(bad), 32'd0);
        chk("product", 32'(out_product), 32'(p));
        bad2 = 0;
        for (int h = 0; h < hold; h++) begin
            if (!out_valid || out_product !== p || in_ready || !busy) bad2++;
            if (lat > 1 && (mult_a !== a || mult_b !== b)) bad2++;
            @(negedge clk);
        end
        chk("backpressure_hold", 32'(bad2), 32'd0);
        chk("valid_before_accept", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        exp_ops++;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_accept", 32'(out_valid), 32'd0);
        chk("in_ready_after_accept", 32'(in_ready), 32'd1);
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic [15:0] p;
        int          lat;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [15:0] q[$];
        int sent;
        int got;
        int cyc;
        int stray;
        logic acc_in;
        logic acc_out;
        vecs[0] = '{8'd13, 8'd11, 0, 16'h008F, 12};
        vecs[1] = '{8'd255, 8'd255, 2, 16'hFE01, 12};
        vecs[2] = '{8'd0, 8'd77, 0, 16'h0000, 1};
        vecs[3] = '{8'd200, 8'd3, 5, 16'h0258, 12};
        vecs[4] = '{8'd1, 8'd1, 0, 16'h0001, 12};
        vecs[5] = '{8'd77, 8'd0, 1, 16'h0000, 1};
        vecs[6] = '{8'd255, 8'd1, 3, 16'h00FF, 12};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_product", 32'(out_product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        chk("rst_mult_load", 32'(mult_load), 32'd0);
        chk("rst_mult_a", 32'(mult_a), 32'd0);
        chk("rst_mult_b", 32'(mult_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].p, vecs[i].lat);

        // Reset while the multiplier is running (WAIT counter at 4).
        in_a = 8'd9;
        in_b = 8'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_ops = 0;
        chk("midwait_out_valid", 32'(out_valid), 32'd0);
        chk("midwait_busy", 32'(busy), 32'd0);
        chk("midwait_ops_done", 32'(ops_done), 32'd0);
        chk("midwait_in_ready", 32'(in_ready), 32'd1);
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            stray += int'(out_valid);
        end
        chk("midwait_no_output", 32'(stray), 32'd0);
        run_op(8'd7, 8'd6, 0, 16'h002A, 12);

        // Random stream against an in-order scoreboard of a*b.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        in_a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        in_b = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
        while (got < 20 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            acc_in = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_in) begin
                q.push_back(16'(in_a) * 16'(in_b));
                sent++;
            end
            if (acc_out) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL stream_extra: output 0x%0h with nothing pending", out_product);
                end else chk("stream_product", 32'(out_product), 32'(q.pop_front()));
                got++;
            end
            @(negedge clk);
            cyc++;
            if (acc_in) begin
                if (sent == 20) in_valid = 1'b0;
                else begin
                    in_a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    in_b = 8'($urandom_range(0, 255));
                end
            end
        end
        out_ready = 1'b0;
        chk("stream_count", 32'(got), 32'd20);
        chk("stream_ops_done", 32'(ops_done), 32'd20);
        chk("stream_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
